input_port_fifo: RTL
====================

// Module: input_port_fifo
// PURPOSE
//  Input-buffer stage of one router port, directly upstream of the per-output arbiters.
//  Accepts flits from the neighbouring router over the RTS/CTS toggle handshake (CTS pulse per flit).
//  Stores them in a circular buffer and presents the head flit plus an empty flag to routing logic.
//  The head is popped when any output arbiter grants this port.
// PARAMETERS
//  DATA_WIDTH  32  flit width in bits
//  DEPTH       4   buffer entries; power of 2, >= 2
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           synchronous reset, active-high
//  RX          in   DATA_WIDTH  incoming flit from upstream router
//  DRTS        in   1           upstream request-to-send (upstream's RTS)
//  read_en_N   in   1           pop request, from the N output arbiter grant
//  read_en_E   in   1           pop request, from the E output arbiter grant
//  read_en_W   in   1           pop request, from the W output arbiter grant
//  read_en_S   in   1           pop request, from the S output arbiter grant
//  read_en_L   in   1           pop request, from the L output arbiter grant
//  CTS         out  1           clear-to-send to upstream (upstream's DCTS); registered
//  empty       out  1           buffer holds no flits
//  Data_out    out  DATA_WIDTH  head flit (mem[rd_ptr]), valid when empty==0
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=0, count=0, all entries=0, CTS=0, empty=1, Data_out=0.
//  - Internal flags: full = (count==DEPTH); empty = (count==0). Both come from registered count.
//  - CTS_in = DRTS & ~CTS & ~full. CTS <= CTS_in each cycle.
//    CTS is therefore a single-cycle pulse per accepted flit and never high two cycles in a row.
//  - Write: write_en = CTS_in. On write_en, mem[wr_ptr] <= RX and wr_ptr <= wr_ptr+1 (mod DEPTH).
//    RX is sampled in the cycle that CTS_in is high. CTS rises the following cycle.
//  - Upstream drops RTS on seeing CTS high. DRTS held through the CTS cycle is not re-accepted,
//    because CTS==1 blocks CTS_in.
//  - Read: read_en = (read_en_N|read_en_E|read_en_W|read_en_S|read_en_L) & ~empty.
//    On read_en, rd_ptr <= rd_ptr+1 (mod DEPTH). The popped entry is not cleared.
//  - count: +1 on write only, -1 on read only, unchanged on both or neither.
//  - Latency: flit accepted at edge k is visible on Data_out with empty=0 after edge k
//    (earliest cycle k+1) when the buffer was empty.
//  - Full: CTS_in is forced 0 and DRTS waits. A read in the same cycle does not free space
//    until the next cycle, so write and read are never both accepted while full.
//  - Empty: read requests are ignored and pointers hold. A simultaneous write proceeds;
//    the flit is poppable next cycle.
//  - Simultaneous read+write while 0<count<DEPTH: both proceed and count holds.
//  - Wrap-around: pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//  - More than one read_en_* high is a protocol violation by the arbiters.
//    It still pops exactly one entry.
//  - Reset mid-operation: all in-flight flits are discarded and CTS drops on the next edge.
//    Upstream must restart its handshake.
// CONFIGURATION
//  FIFO_ERR_CHECK_EN defined: adds output err_fifo [2:0], registered, sticky until rst, reset 0.
//    bit0: read_en_* not one-hot-or-zero.
//    bit1: any read_en_* while empty.
//    bit2: DRTS high while full for more than 2*DEPTH consecutive cycles (stall watchdog).
//  FIFO_ERR_CHECK_EN undefined: port and logic absent; data-path behaviour identical.
// TESTING
//  T1 reset: assert rst 2 cycles -> CTS=0, empty=1, Data_out=0.
//    Deassert, DRTS=0 for 5 cycles -> no change.
//  T2 single flit: DRTS=1, RX=32'hA5A5_0001 -> CTS=1 one cycle later for exactly 1 cycle;
//    empty=0, Data_out=32'hA5A5_0001. Pulse read_en_E -> empty=1 next cycle.
//  T3 fill: hold DRTS=1 with RX=1,2,3,4,5 -> CTS pulses every other cycle, 4 flits accepted.
//    Stays 0 while full. Pulse read_en_L -> Data_out=2 and one more CTS pulse accepts 5.
//  T4 wrap + concurrent: stream 12 flits (values 1..12) with read_en_N high whenever empty=0
//    -> Data_out sequence 1..12 in order, no loss or duplication, pointers wrap 3 times.
//  T5 illegal pops: read_en_W=1 while empty -> pointers and empty unchanged.
//    With FIFO_ERR_CHECK_EN, err_fifo[1]=1.
//    read_en_N=read_en_S=1 with 2 flits -> exactly one pop; err_fifo[0]=1.
//  T6 reset mid-stream: 3 flits stored, rst=1 for 1 cycle -> empty=1, CTS=0, Data_out=0.
//    Next DRTS is accepted normally into entry 0.

Source files
------------

// File: rtl/input_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : input_port_fifo
//  Function : Router input-port buffer. Accepts flits from the upstream
//             router over an RTS/CTS toggle handshake (one CTS pulse per
//             flit) into a circular buffer. Presents the head flit and an
//             empty flag to the routing logic. Pops the head when any
//             output arbiter grants this port.
//  Options  : FIFO_ERR_CHECK_EN - adds sticky protocol-error flags err_fifo
//  Revision : 1.0 - initial release
// ============================================================================
module input_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] Data_out
`ifdef FIFO_ERR_CHECK_EN
  ,
  output logic [2:0]            err_fifo
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  // State
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  cts_q,    cts_d;

  // Control
  logic       full;
  logic       cts_in;
  logic       write_en;
  logic [4:0] read_vec;
  logic       read_req;
  logic       read_en;

  // Flags derive from the registered count only, so a pop in a full cycle
  // cannot open space for a write until the following cycle.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == CNT_ZERO);
  assign CTS      = cts_q;
  assign Data_out = mem_q[rd_ptr_q];

  // Handshake and pop qualification; CTS high blocks re-acceptance of a held DRTS
  always_comb begin
    read_vec = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
    read_req = |read_vec;
    read_en  = read_req & ~empty;
    cts_in   = DRTS & ~cts_q & ~full;
    write_en = cts_in;
  end

  // Next-state for pointers, occupancy count, CTS and storage
  always_comb begin
    cts_d    = cts_in;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (write_en) begin
      mem_d[wr_ptr_q] = RX;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    // Popped entries are left in place; only the read pointer moves.
    if (read_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({write_en, read_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every stored flit and drops CTS
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef FIFO_ERR_CHECK_EN
  // Stall watchdog counts consecutive cycles of DRTS held against a full
  // buffer and saturates at the trip threshold.
  localparam int                 SW         = $clog2(2 * DEPTH + 1) + 1;
  localparam logic [SW-1:0]      STALL_LIM  = SW'(2 * DEPTH);
  localparam logic [SW-1:0]      STALL_ONE  = SW'(1);

  logic [2:0]    err_q,   err_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          multi_grant;
  logic          pop_empty;
  logic          stalled;
  logic          stall_trip;

  // Sticky error detection
  always_comb begin
    multi_grant = ((read_vec & (read_vec - 5'd1)) != 5'd0);
    pop_empty   = read_req & empty;
    stalled     = DRTS & full;
    stall_trip  = stalled & (stall_q >= STALL_LIM);
    if (!stalled) begin
      stall_d = '0;
    end else if (stall_q >= STALL_LIM) begin
      stall_d = stall_q;
    end else begin
      stall_d = stall_q + STALL_ONE;
    end
    err_d = err_q | {stall_trip, pop_empty, multi_grant};
  end

  // Error flag and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= '0;
      stall_q <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign err_fifo = err_q;
`else
  // Error checking is not built; the data path is unaffected.
`endif

endmodule
`default_nettype wire
